score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter LEFT_GOAL_X, default 10'd0: ball_x at or below this value is a goal against the left pad.
REQ-002 SHALL have parameter RIGHT_GOAL_X, default 10'd639: ball_x at or above this value is a goal against the right pad.
REQ-003 SHALL have parameter WIN_SCORE, default 8'h11: the score that ends the game, as two BCD digits (11).
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 25'd25000000: goal lockout length, in clk cycles.
REQ-005 SHALL have parameter BLINK_CYCLES, default 25'd12500000: half-period of the winner's blinking digits, in clk cycles.
REQ-006 SHALL have port clk, input, 1 bit: VGA-domain clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port new_game, input, 1 bit: single-cycle pulse that clears the scores and restarts play.
REQ-009 SHALL have port ball_x, input, 10 bits: ball horizontal position from game logic.
REQ-010 SHALL have ports hex_left_tens, hex_left_ones, hex_right_tens, hex_right_ones, outputs, 7 bits each: active-low segments, bit0 = a through bit6 = g.
REQ-011 SHALL have ports score_left and score_right, outputs, 8 bits each: BCD score, tens digit in [7:4].
REQ-012 SHALL have ports goal_left and goal_right, outputs, 1 bit each: single-cycle pulse when that player scores.
REQ-013 SHALL have ports game_over (output, 1 bit) and winner (output, 1 bit; 0 = left, 1 = right).

Function
REQ-014 SHALL register ball_x every cycle into prev_x.
REQ-015 SHALL detect a right-player goal in cycle N when prev_x > LEFT_GOAL_X and ball_x <= LEFT_GOAL_X, and a left-player goal when prev_x < RIGHT_GOAL_X and ball_x >= RIGHT_GOAL_X.
REQ-016 SHALL implement states PLAY, HOLDOFF and OVER, and act on goals only in PLAY.
REQ-017 SHALL, on a goal detected in cycle N in PLAY, assert the matching goal_* pulse, increment the matching score, and change state, all visible at cycle N+1.
REQ-018 SHALL show the updated score on the hex_* outputs at N+2, because the segment outputs are registered.
REQ-019 SHALL increment scores in BCD: the ones digit 9 -> 0 carries into tens, and 99 -> 00 wraps.
REQ-020 SHALL go to OVER if the incremented score equals WIN_SCORE, latching game_over=1 and winner; otherwise it SHALL go to HOLDOFF.
REQ-021 SHALL, in HOLDOFF, ignore goal detections for exactly HOLDOFF_CYCLES cycles, then return to PLAY.
REQ-022 SHALL still track prev_x during HOLDOFF, so an edge that started inside the holdoff is not counted later.
REQ-023 SHALL, in OVER, freeze both scores and ignore goals.
REQ-024 SHALL, in OVER, toggle the winner's two hex digits between the digit pattern and all-off (7'h7F) every BLINK_CYCLES cycles, starting with the pattern shown.
REQ-025 SHALL keep the loser's digits steady in OVER.
REQ-026 SHALL, on new_game in any state, clear both scores to 8'h00, game_over, winner, the holdoff counter and the blink counter, and go to PLAY next cycle.
REQ-027 SHALL give new_game priority over a goal detected in the same cycle: no pulse, no increment.
REQ-028 SHALL blank a zero tens digit (7'h7F) and always show the ones digit.
REQ-029 SHALL decode BCD 0-9 with standard patterns (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00) and any non-BCD nibble to 7'h7F.

Reset
REQ-030 SHALL, while rst=1, hold state PLAY, both scores 8'h00, goal pulses 0, game_over 0, winner 0, both counters 0, and prev_x = 10'd320.
REQ-031 SHALL, while rst=1, hold hex_*_tens = 7'h7F and hex_*_ones = 7'h40.
REQ-032 SHALL, when rst is asserted mid-HOLDOFF or mid-OVER, abandon that operation and reach the reset state on the next edge.
REQ-033 SHALL give rst priority over new_game.

Verification
REQ-034 SHALL cover: ball_x 5 -> 0 in PLAY -> goal_right=1 for one cycle, score_right 8'h01, hex_right_ones=7'h79 two cycles after detection.
REQ-035 SHALL cover: ball_x held at 0 for 3 cycles after a goal, then 0 -> 320 -> 0 within HOLDOFF_CYCLES (set to 10) -> exactly one increment.
REQ-036 SHALL cover: score_left 8'h09 plus a left goal -> 8'h10, hex_left_tens=7'h79, hex_left_ones=7'h40.
REQ-037 SHALL cover: score_left 8'h10 plus a left goal -> game_over=1, winner=0, left digits blink with period 2*BLINK_CYCLES, and later goals are ignored.
REQ-038 SHALL cover: new_game in the same cycle as a goal -> no pulse, scores 8'h00, state PLAY.
REQ-039 SHALL cover: rst asserted in OVER -> next cycle game_over=0, hex outputs 7'h7F / 7'h40, no blinking.

Source files
------------

// File: rtl/score_keeper.sv
// Score keeper for the VGA pong game: spots goals from the ball position,
// keeps BCD scores, runs the play/holdoff/game-over sequencing and drives
// four active-low seven-segment digits with a blinking winner display.
module score_keeper #(
    parameter logic [9:0]  LEFT_GOAL_X    = 10'd0,
    parameter logic [9:0]  RIGHT_GOAL_X   = 10'd639,
    parameter logic [7:0]  WIN_SCORE      = 8'h11,
    parameter logic [24:0] HOLDOFF_CYCLES = 25'd25000000,
    parameter logic [24:0] BLINK_CYCLES   = 25'd12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic [9:0] ball_x,
    output logic [6:0] hex_left_tens,
    output logic [6:0] hex_left_ones,
    output logic [6:0] hex_right_tens,
    output logic [6:0] hex_right_ones,
    output logic [7:0] score_left,
    output logic [7:0] score_right,
    output logic       goal_left,
    output logic       goal_right,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        HOLDOFF = 2'd1,
        OVER    = 2'd2
    } state_t;

    localparam logic [24:0] HOLD_LAST  = HOLDOFF_CYCLES - 25'd1;
    localparam logic [24:0] BLINK_LAST = BLINK_CYCLES - 25'd1;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [6:0]  SEG_ZERO   = 7'h40;

    state_t      state_q;
    logic [9:0]  prevX_q;
    logic [7:0]  scoreLeft_q;
    logic [7:0]  scoreRight_q;
    logic        goalLeft_q;
    logic        goalRight_q;
    logic        gameOver_q;
    logic        winner_q;
    logic [24:0] holdCnt_q;
    logic [24:0] blinkCnt_q;
    logic        blinkOff_q;

    logic        leftHit_d;
    logic        rightHit_d;
    logic [7:0]  nextLeft_d;
    logic [7:0]  nextRight_d;

    logic [6:0]  hexLeftTens_q;
    logic [6:0]  hexLeftOnes_q;
    logic [6:0]  hexRightTens_q;
    logic [6:0]  hexRightOnes_q;
    logic [6:0]  hexLeftTens_d;
    logic [6:0]  hexLeftOnes_d;
    logic [6:0]  hexRightTens_d;
    logic [6:0]  hexRightOnes_d;

    // BCD increment of a two-digit score; 99 rolls over to 00.
    function automatic logic [7:0] bcdInc(input logic [7:0] s);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = s[7:4];
        ones = s[3:0];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // Active-low seven-segment pattern, bit0 = a .. bit6 = g.
    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Goal edges compare this cycle's ball position with last cycle's, plus the incremented scores.
    always_comb begin
        leftHit_d   = (prevX_q < RIGHT_GOAL_X) && (ball_x >= RIGHT_GOAL_X);
        rightHit_d  = (prevX_q > LEFT_GOAL_X) && (ball_x <= LEFT_GOAL_X);
        nextLeft_d  = bcdInc(scoreLeft_q);
        nextRight_d = bcdInc(scoreRight_q);
    end

    // Game sequencing: scoring in PLAY, goal lockout in HOLDOFF, frozen scores and blink timing in OVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PLAY;
            prevX_q      <= 10'd320;
            scoreLeft_q  <= 8'h00;
            scoreRight_q <= 8'h00;
            goalLeft_q   <= 1'b0;
            goalRight_q  <= 1'b0;
            gameOver_q   <= 1'b0;
            winner_q     <= 1'b0;
            holdCnt_q    <= 25'd0;
            blinkCnt_q   <= 25'd0;
            blinkOff_q   <= 1'b0;
        end else begin
            prevX_q     <= ball_x;
            goalLeft_q  <= 1'b0;
            goalRight_q <= 1'b0;
            if (new_game) begin
                state_q      <= PLAY;
                scoreLeft_q  <= 8'h00;
                scoreRight_q <= 8'h00;
                gameOver_q   <= 1'b0;
                winner_q     <= 1'b0;
                holdCnt_q    <= 25'd0;
                blinkCnt_q   <= 25'd0;
                blinkOff_q   <= 1'b0;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (leftHit_d || rightHit_d) begin
                            goalLeft_q  <= leftHit_d;
                            goalRight_q <= rightHit_d;
                            if (leftHit_d) begin
                                scoreLeft_q <= nextLeft_d;
                            end
                            if (rightHit_d) begin
                                scoreRight_q <= nextRight_d;
                            end
                            blinkCnt_q <= 25'd0;
                            blinkOff_q <= 1'b0;
                            holdCnt_q  <= 25'd0;
                            if (leftHit_d && (nextLeft_d == WIN_SCORE)) begin
                                state_q    <= OVER;
                                gameOver_q <= 1'b1;
                                winner_q   <= 1'b0;
                            end else if (rightHit_d && (nextRight_d == WIN_SCORE)) begin
                                state_q    <= OVER;
                                gameOver_q <= 1'b1;
                                winner_q   <= 1'b1;
                            end else begin
                                state_q <= HOLDOFF;
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (holdCnt_q == HOLD_LAST) begin
                            holdCnt_q <= 25'd0;
                            state_q   <= PLAY;
                        end else begin
                            holdCnt_q <= holdCnt_q + 25'd1;
                        end
                    end
                    OVER: begin
                        if (blinkCnt_q == BLINK_LAST) begin
                            blinkCnt_q <= 25'd0;
                            blinkOff_q <= ~blinkOff_q;
                        end else begin
                            blinkCnt_q <= blinkCnt_q + 25'd1;
                        end
                    end
                    default: begin
                        state_q <= PLAY;
                    end
                endcase
            end
        end
    end

    // Digit patterns: leading zero blanked, winner's pair dark during the off half of the blink.
    always_comb begin
        hexLeftTens_d  = (scoreLeft_q[7:4] == 4'd0) ? SEG_OFF : segDecode(scoreLeft_q[7:4]);
        hexLeftOnes_d  = segDecode(scoreLeft_q[3:0]);
        hexRightTens_d = (scoreRight_q[7:4] == 4'd0) ? SEG_OFF : segDecode(scoreRight_q[7:4]);
        hexRightOnes_d = segDecode(scoreRight_q[3:0]);
        if (gameOver_q && blinkOff_q) begin
            if (winner_q) begin
                hexRightTens_d = SEG_OFF;
                hexRightOnes_d = SEG_OFF;
            end else begin
                hexLeftTens_d = SEG_OFF;
                hexLeftOnes_d = SEG_OFF;
            end
        end
    end

    // Segment outputs are registered, so they trail the score registers by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hexLeftTens_q  <= SEG_OFF;
            hexLeftOnes_q  <= SEG_ZERO;
            hexRightTens_q <= SEG_OFF;
            hexRightOnes_q <= SEG_ZERO;
        end else begin
            hexLeftTens_q  <= hexLeftTens_d;
            hexLeftOnes_q  <= hexLeftOnes_d;
            hexRightTens_q <= hexRightTens_d;
            hexRightOnes_q <= hexRightOnes_d;
        end
    end

    assign hex_left_tens  = hexLeftTens_q;
    assign hex_left_ones  = hexLeftOnes_q;
    assign hex_right_tens = hexRightTens_q;
    assign hex_right_ones = hexRightOnes_q;
    assign score_left     = scoreLeft_q;
    assign score_right    = scoreRight_q;
    assign goal_left      = goalLeft_q;
    assign goal_right     = goalRight_q;
    assign game_over      = gameOver_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a hand-derived vector table, directed corner-case
// sequences and a randomized run, all checked against a score/timer model.
module tb_score_keeper;

    localparam int H = 10;
    localparam int B = 4;

    logic       clk;
    logic       rst;
    logic       newGame;
    logic [9:0] ballX;
    logic [6:0] hexLeftTens, hexLeftOnes, hexRightTens, hexRightOnes;
    logic [7:0] scoreLeft, scoreRight;
    logic       goalLeft, goalRight, gameOver, winner;

    int checks = 0;
    int errors = 0;

    // model of the game in plain integers
    int mPrev, mScoreL, mScoreR, mOver, mWinner, mHolding, mHoldAge, mOverAge, mGoalL, mGoalR;
    logic [6:0] mHexLT, mHexLO, mHexRT, mHexRO;

    typedef struct {
        logic       r;
        logic       ng;
        int         bx;
        logic       expGoalL;
        logic       expGoalR;
        logic [7:0] expScoreL;
        logic [7:0] expScoreR;
        logic       expOver;
    } vec_t;

    vec_t table_q[16];

    score_keeper #(
        .LEFT_GOAL_X   (10'd0),
        .RIGHT_GOAL_X  (10'd639),
        .WIN_SCORE     (8'h11),
        .HOLDOFF_CYCLES(25'(H)),
        .BLINK_CYCLES  (25'(B))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .new_game      (newGame),
        .ball_x        (ballX),
        .hex_left_tens (hexLeftTens),
        .hex_left_ones (hexLeftOnes),
        .hex_right_tens(hexRightTens),
        .hex_right_ones(hexRightOnes),
        .score_left    (scoreLeft),
        .score_right   (scoreRight),
        .goal_left     (goalLeft),
        .goal_right    (goalRight),
        .game_over     (gameOver),
        .winner        (winner)
    );

    // free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] toBcd(input int s);
        return 8'(((s / 10) * 16) + (s % 10));
    endfunction

    function automatic vec_t mkVec(input logic r, input int bx, input logic gl, input logic gr,
                                   input logic [7:0] sl, input logic [7:0] sr);
        vec_t v;
        v.r = r; v.ng = 1'b0; v.bx = bx;
        v.expGoalL = gl; v.expGoalR = gr;
        v.expScoreL = sl; v.expScoreR = sr; v.expOver = 1'b0;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // advance the model by one clock edge using the inputs present before it
    task automatic modelStep(input logic r, input logic ng, input int bx);
        bit blank, lHit, rHit;
        if (r) begin
            mHexLT = 7'h7F; mHexLO = 7'h40; mHexRT = 7'h7F; mHexRO = 7'h40;
        end else begin
            blank  = (mOver != 0) && (((mOverAge / B) % 2) == 1);
            mHexLT = (mScoreL / 10 == 0) ? 7'h7F : segOf(mScoreL / 10);
            mHexLO = segOf(mScoreL % 10);
            mHexRT = (mScoreR / 10 == 0) ? 7'h7F : segOf(mScoreR / 10);
            mHexRO = segOf(mScoreR % 10);
            if (blank && mWinner == 0) begin mHexLT = 7'h7F; mHexLO = 7'h7F; end
            if (blank && mWinner == 1) begin mHexRT = 7'h7F; mHexRO = 7'h7F; end
        end
        mGoalL = 0;
        mGoalR = 0;
        if (r) begin
            mPrev = 320; mScoreL = 0; mScoreR = 0; mOver = 0; mWinner = 0;
            mHolding = 0; mHoldAge = 0; mOverAge = 0;
        end else begin
            lHit = (mPrev < 639) && (bx >= 639);
            rHit = (mPrev > 0) && (bx <= 0);
            if (ng) begin
                mScoreL = 0; mScoreR = 0; mOver = 0; mWinner = 0;
                mHolding = 0; mHoldAge = 0; mOverAge = 0;
            end else if (mOver != 0) begin
                mOverAge++;
            end else if (mHolding != 0) begin
                mHoldAge++;
                if (mHoldAge == H) mHolding = 0;
            end else if (lHit || rHit) begin
                if (lHit) begin mScoreL = (mScoreL + 1) % 100; mGoalL = 1; end
                if (rHit) begin mScoreR = (mScoreR + 1) % 100; mGoalR = 1; end
                if (lHit && mScoreL == 11) begin
                    mOver = 1; mWinner = 0; mOverAge = 0;
                end else if (rHit && mScoreR == 11) begin
                    mOver = 1; mWinner = 1; mOverAge = 0;
                end else begin
                    mHolding = 1; mHoldAge = 0;
                end
            end
            mPrev = bx;
        end
    endtask

    task automatic checkOutput();
        checkVal("score_left",     32'(scoreLeft),    32'(toBcd(mScoreL)));
        checkVal("score_right",    32'(scoreRight),   32'(toBcd(mScoreR)));
        checkVal("goal_left",      32'(goalLeft),     32'(mGoalL));
        checkVal("goal_right",     32'(goalRight),    32'(mGoalR));
        checkVal("game_over",      32'(gameOver),     32'(mOver));
        checkVal("winner",         32'(winner),       32'(mWinner));
        checkVal("hex_left_tens",  32'(hexLeftTens),  32'(mHexLT));
        checkVal("hex_left_ones",  32'(hexLeftOnes),  32'(mHexLO));
        checkVal("hex_right_tens", 32'(hexRightTens), 32'(mHexRT));
        checkVal("hex_right_ones", 32'(hexRightOnes), 32'(mHexRO));
    endtask

    // drive one cycle of inputs, clock them in, then compare against the model
    task automatic applyStimulus(input logic r, input logic ng, input int bx);
        rst     = r;
        newGame = ng;
        ballX   = 10'(bx);
        @(posedge clk);
        modelStep(r, ng, bx);
        #1;
        checkOutput();
    endtask

    // wait out any holdoff with the ball mid-field, then cross a goal line
    task automatic scoreGoal(input int bx);
        repeat (H + 2) applyStimulus(1'b0, 1'b0, 320);
        applyStimulus(1'b0, 1'b0, bx);
    endtask

    initial begin
        int sel, bx;
        logic r, ng;
        rst = 1'b1; newGame = 1'b0; ballX = 10'd320;
        mPrev = 320; mScoreL = 0; mScoreR = 0; mOver = 0; mWinner = 0;
        mHolding = 0; mHoldAge = 0; mOverAge = 0; mGoalL = 0; mGoalR = 0;
        mHexLT = 7'h7F; mHexLO = 7'h40; mHexRT = 7'h7F; mHexRO = 7'h40;

        // hand-derived vectors: reset, right goal, edge inside holdoff ignored, left goal after holdoff
        table_q[0]  = mkVec(1'b1, 320, 1'b0, 1'b0, 8'h00, 8'h00);
        table_q[1]  = mkVec(1'b0, 5,   1'b0, 1'b0, 8'h00, 8'h00);
        table_q[2]  = mkVec(1'b0, 0,   1'b0, 1'b1, 8'h00, 8'h01);
        table_q[3]  = mkVec(1'b0, 0,   1'b0, 1'b0, 8'h00, 8'h01);
        table_q[4]  = mkVec(1'b0, 0,   1'b0, 1'b0, 8'h00, 8'h01);
        table_q[5]  = mkVec(1'b0, 0,   1'b0, 1'b0, 8'h00, 8'h01);
        table_q[6]  = mkVec(1'b0, 320, 1'b0, 1'b0, 8'h00, 8'h01);
        table_q[7]  = mkVec(1'b0, 0,   1'b0, 1'b0, 8'h00, 8'h01);
        for (int i = 8; i <= 13; i++) table_q[i] = mkVec(1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h01);
        table_q[14] = mkVec(1'b0, 639, 1'b1, 1'b0, 8'h01, 8'h01);
        table_q[15] = mkVec(1'b0, 639, 1'b0, 1'b0, 8'h01, 8'h01);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(table_q[i].r, table_q[i].ng, table_q[i].bx);
            checkVal($sformatf("tbl%0d.goal_left", i),   32'(goalLeft),   32'(table_q[i].expGoalL));
            checkVal($sformatf("tbl%0d.goal_right", i),  32'(goalRight),  32'(table_q[i].expGoalR));
            checkVal($sformatf("tbl%0d.score_left", i),  32'(scoreLeft),  32'(table_q[i].expScoreL));
            checkVal($sformatf("tbl%0d.score_right", i), 32'(scoreRight), 32'(table_q[i].expScoreR));
            checkVal($sformatf("tbl%0d.game_over", i),   32'(gameOver),   32'(table_q[i].expOver));
            if (i == 0) begin
                checkVal("tbl0.hex_left_tens", 32'(hexLeftTens), 32'h7F);
                checkVal("tbl0.hex_left_ones", 32'(hexLeftOnes), 32'h40);
            end
            if (i == 3) checkVal("tbl3.hex_right_ones", 32'(hexRightOnes), 32'h79);
        end

        // left player climbs from 09 to 10, then wins at 11 and the left pair blinks
        applyStimulus(1'b0, 1'b1, 320);
        repeat (9) scoreGoal(639);
        checkVal("seq.left09", 32'(scoreLeft), 32'h09);
        scoreGoal(639);
        checkVal("seq.left10", 32'(scoreLeft), 32'h10);
        applyStimulus(1'b0, 1'b0, 320);
        checkVal("seq.left10.tens", 32'(hexLeftTens), 32'h79);
        checkVal("seq.left10.ones", 32'(hexLeftOnes), 32'h40);
        scoreGoal(639);
        checkVal("seq.win.over",   32'(gameOver), 32'h1);
        checkVal("seq.win.winner", 32'(winner),   32'h0);
        applyStimulus(1'b0, 1'b0, 320);
        checkVal("seq.blink.on1",  32'(hexLeftOnes), 32'h79);
        repeat (B) applyStimulus(1'b0, 1'b0, 320);
        checkVal("seq.blink.off",  32'(hexLeftOnes), 32'h7F);
        checkVal("seq.blink.offT", 32'(hexLeftTens), 32'h7F);
        checkVal("seq.loser.ones", 32'(hexRightOnes), 32'h40);
        repeat (B) applyStimulus(1'b0, 1'b0, 320);
        checkVal("seq.blink.on2",  32'(hexLeftOnes), 32'h79);
        applyStimulus(1'b0, 1'b0, 639);
        checkVal("seq.over.noGoalL", 32'(goalLeft),  32'h0);
        checkVal("seq.over.frozenL", 32'(scoreLeft), 32'h11);
        applyStimulus(1'b0, 1'b0, 0);
        checkVal("seq.over.frozenR", 32'(scoreRight), 32'h00);

        // new_game wins over a goal edge in the same cycle
        applyStimulus(1'b0, 1'b1, 320);
        scoreGoal(0);
        repeat (H + 2) applyStimulus(1'b0, 1'b0, 320);
        applyStimulus(1'b0, 1'b1, 639);
        checkVal("seq.ng.noPulse", 32'(goalLeft),   32'h0);
        checkVal("seq.ng.left",    32'(scoreLeft),  32'h00);
        checkVal("seq.ng.right",   32'(scoreRight), 32'h00);
        applyStimulus(1'b0, 1'b0, 320);
        applyStimulus(1'b0, 1'b0, 639);
        checkVal("seq.ng.play", 32'(goalLeft), 32'h1);

        // reset while the right player's win is blinking
        applyStimulus(1'b0, 1'b1, 320);
        repeat (11) scoreGoal(0);
        checkVal("seq.rwin.over",   32'(gameOver), 32'h1);
        checkVal("seq.rwin.winner", 32'(winner),   32'h1);
        repeat (B + 2) applyStimulus(1'b0, 1'b0, 320);
        applyStimulus(1'b1, 1'b0, 320);
        checkVal("seq.rst.over",  32'(gameOver),     32'h0);
        checkVal("seq.rst.rt",    32'(hexRightTens), 32'h7F);
        checkVal("seq.rst.ro",    32'(hexRightOnes), 32'h40);
        checkVal("seq.rst.score", 32'(scoreRight),   32'h00);
        for (int i = 0; i < 2 * B + 2; i++) begin
            applyStimulus(1'b0, 1'b0, 320);
            checkVal("seq.rst.steady", 32'(hexRightOnes), 32'h40);
        end

        // randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 999) < 3);
            ng  = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 9);
            if (sel <= 3)      bx = 320;
            else if (sel <= 5) bx = 0;
            else if (sel <= 7) bx = 639;
            else if (sel == 8) bx = $urandom_range(0, 1023);
            else               bx = $urandom_range(1, 638);
            applyStimulus(r, ng, bx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
